// File: rtl/nibble_pair_sequencer.sv
// Latches two operands on start, then streams every (A slice, B slice) pair with its shift on valid/ready.
// First pair one cycle after start, one pair per cycle; out_ready low holds the presented pair.
module nibble_pair_sequencer #(
  parameter  int DATA_W  = 8,
  parameter  int NIB_W   = 4,
  localparam int NUM     = DATA_W / NIB_W,
  localparam int SHIFT_W = $clog2(2 * DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  dataa,
  input  logic [DATA_W-1:0]  datab,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NIB_W-1:0]   mux_out_a,
  output logic [NIB_W-1:0]   mux_out_b,
  output logic [SHIFT_W-1:0] shift,
  output logic               first,
  output logic               last,
  output logic               done
);
  localparam int CNT_W = $clog2(NUM);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [CNT_W-1:0]    r_i;
  logic [CNT_W-1:0]    r_j;
  logic                w_valid;
  logic                w_load;
  logic                w_xfer;
  logic                w_at_last;

  assign w_at_last = (r_i == C_MAX) && (r_j == C_MAX);
  assign w_xfer    = w_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_valid     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (out_ready && w_at_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // i is the inner (A) index; j advances when i wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_i     <= '0;
      r_j     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_opa <= dataa;
        r_opb <= datab;
        r_i   <= '0;
        r_j   <= '0;
      end else if (w_xfer && !w_at_last) begin
        if (r_i == C_MAX) begin
          r_i <= '0;
          r_j <= r_j + 1'b1;
        end else begin
          r_i <= r_i + 1'b1;
        end
      end
    end
  end

  assign out_valid = w_valid;
  assign mux_out_a = w_valid ? r_opa[int'(r_i) * NIB_W +: NIB_W] : '0;
  assign mux_out_b = w_valid ? r_opb[int'(r_j) * NIB_W +: NIB_W] : '0;
  assign shift     = w_valid ? SHIFT_W'((int'(r_i) + int'(r_j)) * NIB_W) : '0;
  assign first     = w_valid && (r_i == '0) && (r_j == '0);
  assign last      = w_valid && w_at_last;

endmodule

// File: tb/tb_nibble_pair_sequencer.sv
// Bench for nibble_pair_sequencer: cycle vector table on an 8-bit instance, model-checked random runs on a 16-bit one.
module tb_nibble_pair_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r8, s8, rdy8, bsy8, vld8, fi8, la8, dn8;
  logic [7:0] da8, db8;
  logic [3:0] a8, b8, sh8;

  logic        r16, s16, rdy16, bsy16, vld16, fi16, la16, dn16;
  logic [15:0] da16, db16;
  logic [3:0]  a16, b16;
  logic [4:0]  sh16;

  nibble_pair_sequencer #(.DATA_W(8), .NIB_W(4)) dut8 (
    .clk(clk), .reset(r8), .start(s8), .dataa(da8), .datab(db8), .busy(bsy8),
    .out_valid(vld8), .out_ready(rdy8), .mux_out_a(a8), .mux_out_b(b8), .shift(sh8),
    .first(fi8), .last(la8), .done(dn8));

  nibble_pair_sequencer #(.DATA_W(16), .NIB_W(4)) dut16 (
    .clk(clk), .reset(r16), .start(s16), .dataa(da16), .datab(db16), .busy(bsy16),
    .out_valid(vld16), .out_ready(rdy16), .mux_out_a(a16), .mux_out_b(b16), .shift(sh16),
    .first(fi16), .last(la16), .done(dn16));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic       rst, st, rdy;
    logic [7:0] da, db;
    logic       bsy, vld;
    logic [3:0] a, b, sh;
    logic       fi, la, dn;
  } vec_t;

  vec_t vq[$];

  function automatic void idl(input logic rst, input logic st, input logic [7:0] da, input logic [7:0] db);
    vec_t v = '{rst, st, 1'b1, da, db, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vq.push_back(v);
  endfunction

  function automatic void pr(input logic rst, input logic st, input logic rdy, input logic [7:0] da,
                             input logic [7:0] db, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] sh, input logic fi, input logic la);
    vec_t v = '{rst, st, rdy, da, db, 1'b1, 1'b1, a, b, sh, fi, la, 1'b0};
    vq.push_back(v);
  endfunction

  function automatic void dne(input logic st, input logic [7:0] da, input logic [7:0] db);
    vec_t v = '{1'b0, st, 1'b1, da, db, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
    vq.push_back(v);
  endfunction

  // Reference pair k for 16-bit operands: A index is the fast index
  function automatic logic [14:0] pair_exp(input logic [15:0] A, input logic [15:0] B, input int k);
    int i = k % 4;
    int j = k / 4;
    logic [3:0] a = 4'((A >> (4 * i)) & 16'hF);
    logic [3:0] b = 4'((B >> (4 * j)) & 16'hF);
    logic [4:0] sh = 5'((i + j) * 4);
    return {a, b, sh, (k == 0), (k == 15)};
  endfunction

  task automatic run16(input logic [15:0] A, input logic [15:0] B, input bit rnd);
    int  k = 0;
    int  c = 0;
    bit  fin = 0;
    bit  rdy;
    @(negedge clk);
    s16 = 1'b1; da16 = A; db16 = B; rdy16 = 1'b1;
    @(negedge clk);
    c = 1;
    s16 = 1'b0; da16 = 16'($urandom); db16 = 16'($urandom);
    while (!fin && c < 300) begin
      if (vld16) begin
        chk($sformatf("pair16_k%0d", k), {17'd0, a16, b16, sh16, fi16, la16},
            {17'd0, (k < 16) ? pair_exp(A, B, k) : 15'h7FFF});
        rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        rdy16 = rdy;
        if (rdy) k++;
      end else if (dn16) begin
        chk("done16_pairs", k, 16);
        if (!rnd) chk("done16_latency", c, 17);
        fin = 1;
        s16 = 1'b0;
      end else begin
        chk("vld16_gap", {31'd0, vld16}, 1);
        fin = 1;
        s16 = 1'b0;
      end
      if (!fin) begin
        @(negedge clk);
        c++;
        s16 = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        da16 = 16'($urandom);
      end
    end
    if (!fin) chk("timeout16", 0, 1);
    @(negedge clk);
    chk("idle16", {29'd0, bsy16, vld16, dn16}, 0);
  endtask

  initial begin
    r8 = 1'b1; s8 = 1'b0; rdy8 = 1'b1; da8 = 8'h00; db8 = 8'h00;
    r16 = 1'b1; s16 = 1'b0; rdy16 = 1'b1; da16 = 16'h0; db16 = 16'h0;

    // basic
    idl(0, 1, 8'hF0, 8'hC3);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h0, 4'h3, 4'd0, 1, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h0, 4'hC, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'hF, 4'hC, 4'd8, 0, 1);
    dne(0, 8'h00, 8'h00);
    idl(0, 0, 8'h00, 8'h00);
    // backpressure on pair 2
    idl(0, 1, 8'hF0, 8'hC3);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h0, 4'h3, 4'd0, 1, 0);
    pr(0, 0, 0, 8'h00, 8'h00, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 0, 8'h00, 8'h00, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 0, 8'h00, 8'h00, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h0, 4'hC, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'hF, 4'hC, 4'd8, 0, 1);
    dne(0, 8'h00, 8'h00);
    idl(0, 0, 8'h00, 8'h00);
    // start while busy is ignored, then a fresh operand pair
    idl(0, 1, 8'hF0, 8'hC3);
    pr(0, 1, 1, 8'hAA, 8'h55, 4'h0, 4'h3, 4'd0, 1, 0);
    pr(0, 1, 1, 8'hAA, 8'h55, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 1, 8'hAA, 8'h55, 4'h0, 4'hC, 4'd4, 0, 0);
    pr(0, 0, 1, 8'hAA, 8'h55, 4'hF, 4'hC, 4'd8, 0, 1);
    dne(1, 8'h12, 8'h34);
    idl(0, 1, 8'h12, 8'h34);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h2, 4'h4, 4'd0, 1, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h1, 4'h4, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h2, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h1, 4'h3, 4'd8, 0, 1);
    dne(0, 8'h00, 8'h00);
    idl(0, 0, 8'h00, 8'h00);
    // reset during pair 3
    idl(0, 1, 8'hF0, 8'hC3);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h0, 4'h3, 4'd0, 1, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(1, 0, 1, 8'h00, 8'h00, 4'h0, 4'hC, 4'd4, 0, 0);
    idl(0, 0, 8'h00, 8'h00);
    idl(0, 1, 8'hF0, 8'hC3);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h0, 4'h3, 4'd0, 1, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'hF, 4'h3, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'h0, 4'hC, 4'd4, 0, 0);
    pr(0, 0, 1, 8'h00, 8'h00, 4'hF, 4'hC, 4'd8, 0, 1);
    dne(0, 8'h00, 8'h00);
    // reset and start together in IDLE
    idl(1, 1, 8'hF0, 8'hC3);
    idl(0, 0, 8'h00, 8'h00);
    idl(0, 0, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    chk("reset16", {15'd0, bsy16, vld16, a16, b16, sh16, fi16, la16, dn16}, 0);
    r16 = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", k), {15'd0, bsy8, vld8, a8, b8, sh8, fi8, la8, dn8},
          {15'd0, vq[k].bsy, vq[k].vld, vq[k].a, vq[k].b, vq[k].sh, vq[k].fi, vq[k].la, vq[k].dn});
      r8 = vq[k].rst; s8 = vq[k].st; rdy8 = vq[k].rdy; da8 = vq[k].da; db8 = vq[k].db;
    end

    run16(16'h4321, 16'h8765, 1'b0);
    for (int n = 0; n < 8; n++) run16(16'($urandom), 16'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_pair_sequencer.md
# nibble_pair_sequencer

Parametrised successor to the 4-bit operand select mux in the sequential multiplier datapath. On `start` it latches two DATA_W-bit operands. It then steps through every pair of NIB_W-bit slices, one A slice against one B slice, and presents each pair with its partial-product shift amount on a valid/ready stream. The downstream NIB_W×NIB_W multiplier and accumulator consume that stream. This replaces the fixed 2-way hi/lo selector with a counter-driven sequencer that handles any operand width and supports backpressure.

## Interface
Parameters:
- DATA_W, 8, operand width; must be an integer multiple of NIB_W.
- NIB_W, 4, slice width fed to the small multiplier.
- Derived values, not overridable:
  - NUM = DATA_W/NIB_W, must be ≥ 2.
  - SHIFT_W = $clog2(2*DATA_W).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- dataa  in  DATA_W  operand A; captured on an accepted start.
- datab  in  DATA_W  operand B; captured on an accepted start.
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  pair presented on mux_out_a/mux_out_b/shift.
- out_ready  in  1  consumer accepts the pair this cycle.
- mux_out_a  out  NIB_W  slice i of latched A: A[i*NIB_W +: NIB_W].
- mux_out_b  out  NIB_W  slice j of latched B: B[j*NIB_W +: NIB_W].
- shift  out  SHIFT_W  partial-product weight, (i+j)*NIB_W.
- first  out  1  marks pair (0,0).
- last  out  1  marks pair (NUM-1, NUM-1).
- done  out  1  one-cycle pulse after the last pair is accepted.

## Operation
- State register holds IDLE, RUN or DONE.
- Internal state: latched opA/opB, slice counters i (A index) and j (B index), each $clog2(NUM) bits.
- IDLE:
  - out_valid=0, busy=0.
  - On start=1: latch dataa/datab, clear i and j to 0, go to RUN.
- RUN:
  - out_valid=1. Output fields are combinational from the registers.
  - A transfer occurs when out_valid && out_ready.
  - On transfer with last=0: i is the inner loop. If i==NUM-1 then i←0 and j←j+1, else i←i+1.
  - On transfer with last=1: go to DONE.
  - No transfer: all registers and outputs hold unchanged.
- DONE: done=1, busy=1, out_valid=0. Go to IDLE next cycle unconditionally.
- Pair order: (i,j) = (0,0),(1,0)…(NUM-1,0),(0,1)…(NUM-1,NUM-1), NUM² pairs total.
- start is ignored in RUN and DONE. dataa/datab changes after capture have no effect.
- When out_valid=0, mux_out_a, mux_out_b, shift, first and last drive 0.

## Timing
- Reset: synchronous. On the cycle after reset is sampled high:
  - state=IDLE, i=j=0, opA=opB=0.
  - busy, out_valid, first, last, done, mux_out_a, mux_out_b and shift are all 0.
- Reset in RUN or DONE abandons the sequence. No done pulse is produced for it.
- reset takes priority over start in the same cycle.
- Latency: start accepted at edge t gives the first pair valid in cycle t+1.
- Throughput: one pair per cycle while out_ready=1.
- With out_ready held at 1:
  - The last pair is valid in cycle t+NUM².
  - done is high in cycle t+NUM²+1.
  - IDLE is reached in cycle t+NUM²+2, where a new start may be accepted.
- Backpressure: out_ready may drop in any cycle. The presented pair stays stable until accepted.
- out_ready has no effect when out_valid=0.

## Test plan
- Basic, DATA_W=8: dataa=8'hF0, datab=8'hC3, start for one cycle, out_ready=1.
  - Required (a,b,shift) sequence: (0,3,0), (F,3,4), (0,C,4), (F,C,8).
  - first is high on pair 1; last is high on pair 4.
  - done pulses exactly one cycle, 5 cycles after start.
- Backpressure: same operands, out_ready=0 for 3 cycles while pair 2 is shown.
  - (F,3,4) is held stable with out_valid=1.
  - Sequence resumes unchanged; done is delayed by 3 cycles.
- Start while busy: pulse start with dataa=8'hAA during RUN.
  - Ignored; remaining pairs still come from F0/C3.
  - After IDLE, start with dataa=8'h12, datab=8'h34 produces (2,4,0), (1,4,4), (2,3,4), (1,3,8).
- Reset mid-sequence: assert reset during pair 3.
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A fresh start then runs the full 4-pair sequence.
- Wide parameter, DATA_W=16: dataa=16'h4321, datab=16'h8765, out_ready=1.
  - 16 pairs; pair k has mux_out_a=(k%4)+1 and mux_out_b=(k/4)+5.
  - shift runs 0 to 24; last is on (4,8,24).
  - done occurs 17 cycles after start.
- Simultaneous reset and start in IDLE: block stays IDLE, out_valid stays 0.
